mod_exp_ctrl: RTL and testbench
===============================

Name: mod_exp_ctrl

Overview:
Square-and-multiply controller that computes z = x^e mod m by sequencing an external mod_mul instance.
- Sits directly upstream of mod_mul: it drives the multiplier's operands and start handshake, and consumes its result/done.
- Forms the exponentiation core for RSA encrypt/decrypt.
- Modulus m lives in the mod_mul instance; this block only orders the operations.

Parameters:
k, 12, operand/exponent width in bits (must match mod_mul k)
logk, 4, width of the exponent bit-index counter; must satisfy 2^logk >= k

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
x  input  k  base; precondition x < m
e  input  k  exponent
z  output  k  result; valid from done, held until next accepted start
done  output  1  one-cycle pulse when z is valid
busy  output  1  high from accepted start until the done cycle, inclusive
mul_x  output  k  operand A to mod_mul
mul_y  output  k  operand B to mod_mul
mul_start  output  1  mod_mul start, level, held until mul_done seen
mul_z  input  k  mod_mul result, valid while mul_done high
mul_done  input  1  mod_mul completion

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - z, mul_x, mul_y, internal registers clear to 0.
  - done, busy, mul_start go to 0.
  - Reset mid-operation aborts with no done pulse; any in-flight mul_done is ignored after reset.
- Registers: xr, er (latched operands), r (accumulator), idx (logk bits), op (SQR/MUL).
- IDLE:
  - On start=1, latch xr=x, er=e, set idx=k-1, busy=1, go to SCAN.
  - start while busy is ignored.
  - start held high after done is re-accepted as a new request in IDLE.
- SCAN (one cycle per bit, no multiplier use):
  - If er==0: r=1, go to FIN.
  - Else if er[idx]==0: idx=idx-1, stay.
  - Else (leading 1 found): r=xr, go to NEXT.
- NEXT:
  - If idx==0: go to FIN.
  - Else: idx=idx-1, op=SQR, go to CALL.
- CALL:
  - mul_start=1; mul_x=r; mul_y=(op==SQR ? r : xr).
  - Operands are stable for the whole time mul_start is high.
  - Wait for mul_done=1. In that cycle: r=mul_z, mul_start=0 next cycle, go to REL.
- REL:
  - mul_start=0; wait for mul_done==0 (covers level-done multipliers).
  - Then:
    - if op==SQR and er[idx]==1: op=MUL, go to CALL;
    - else if op==MUL or er[idx]==0: go to NEXT.
  - mul_start is never re-asserted in the same cycle mul_done is seen low; there is at least one cycle of mul_start=0 between calls.
- FIN: z=r, done=1 for exactly one cycle, busy drops the cycle after, go to IDLE.
- Multiplier call count per operation = (L-1) squarings + (popcount(e)-1) multiplies, where L = bit length of e.
  - e=0 and e=1 make zero calls.
  - e=0 gives z=1 for any x, including x=0.
  - e=1 gives z=x.
- Arithmetic: all values are k bits. No reduction is performed here; correctness relies on x < m and on mod_mul returning a result < m.
- Top exponent bit k-1 is handled the same as every other bit. idx never underflows because NEXT exits on idx==0.

Test Plan:
(m=3551, k=12, bench mod_mul model with 3-cycle latency and level done)
- x=2, e=10 -> z=1024; exactly 4 mul_start rising edges in order SQR,SQR,MUL,SQR; done one cycle; busy drops the cycle after done.
- x=3550, e=3 -> z=3550; 2 calls (SQR then MUL); check mul_x/mul_y stable while mul_start=1.
- x=2, e=12 -> z=545; x=1234, e=1 -> z=1234 with 0 calls; x=0, e=0 -> z=1 with 0 calls.
- x=5, e=0xFFF -> z matches reference model pow(5,4095) mod 3551; 11 SQR + 11 MUL calls.
- start pulsed again mid-operation -> ignored, result unchanged. Then rst_n=0 during a CALL -> all outputs 0 immediately and no done. A fresh start with x=2, e=10 then still gives 1024.
- mod_mul model holds mul_done high 5 cycles -> controller waits in REL; no duplicate result capture; final z correct.

Source files
------------

// File: rtl/mod_exp_ctrl_if.sv
// mod_exp_ctrl_if: operand/handshake bus between mod_exp_ctrl (master) and mod_mul (slave)
//   mul_x, mul_y : operands A and B, stable while mul_start is high
//   mul_start    : level request, held until mul_done is seen
//   mul_z        : product result, valid while mul_done is high
//   mul_done     : completion, may stay high for several cycles
interface mod_exp_ctrl_if #(parameter int k = 12);
    logic [k-1:0] mul_x;
    logic [k-1:0] mul_y;
    logic [k-1:0] mul_z;
    logic         mul_start;
    logic         mul_done;
    modport master (output mul_x, mul_y, mul_start, input mul_z, mul_done);
    modport slave (input mul_x, mul_y, mul_start, output mul_z, mul_done);
endinterface

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer computing z = x^e mod m via an external mod_mul
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, x, e    : request with base and exponent, accepted only when idle
//   z, done, busy  : result (held until next accepted start), one-cycle done pulse, busy flag
//   mm             : master side of the mod_mul bus
module mod_exp_ctrl #(
    parameter int k    = 12,
    parameter int logk = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [k-1:0]  x,
    input  logic [k-1:0]  e,
    output logic [k-1:0]  z,
    output logic          done,
    output logic          busy,
    mod_exp_ctrl_if.master mm
);
    typedef enum logic [2:0] {IDLE, SCAN, NEXT, CALL, REL, FIN} state_t;
    typedef enum logic {SQR, MUL} op_t;
    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [k-1:0]   xr_q, xr_d, er_q, er_d, r_q, r_d, z_q, z_d;
    logic [logk-1:0] idx_q, idx_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= SQR;
            xr_q    <= '0;
            er_q    <= '0;
            r_q     <= '0;
            z_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            xr_q    <= xr_d;
            er_q    <= er_d;
            r_q     <= r_d;
            z_q     <= z_d;
            idx_q   <= idx_d;
        end
    end
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        xr_d    = xr_q;
        er_d    = er_q;
        r_d     = r_q;
        z_d     = z_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (start) begin
                xr_d    = x;
                er_d    = e;
                idx_d   = logk'(k - 1);
                state_d = SCAN;
            end
            // find the leading one; er==0 short-circuits to z=1
            SCAN: if (er_q == '0) begin
                r_d     = k'(1);
                state_d = FIN;
            end else if (!er_q[idx_q]) begin
                idx_d = idx_q - logk'(1);
            end else begin
                r_d     = xr_q;
                state_d = NEXT;
            end
            // exiting on idx==0 is what keeps idx from wrapping
            NEXT: if (idx_q == '0) begin
                state_d = FIN;
            end else begin
                idx_d   = idx_q - logk'(1);
                op_d    = SQR;
                state_d = CALL;
            end
            CALL: if (mm.mul_done) begin
                r_d     = mm.mul_z;
                state_d = REL;
            end
            // wait out a level-style done so one result is never captured twice
            REL: if (!mm.mul_done) begin
                if (op_q == SQR && er_q[idx_q]) begin
                    op_d    = MUL;
                    state_d = CALL;
                end else begin
                    state_d = NEXT;
                end
            end
            FIN: begin
                z_d     = r_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign done         = state_q == FIN;
    assign busy         = state_q != IDLE;
    assign z            = done ? r_q : z_q;
    assign mm.mul_start = state_q == CALL;
    assign mm.mul_x     = mm.mul_start ? r_q : '0;
    assign mm.mul_y     = mm.mul_start ? (op_q == SQR ? r_q : xr_q) : '0;
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl: scoreboard bench for mod_exp_ctrl with a behavioural mod_mul model
module tb_mod_exp_ctrl;
    localparam int k = 12, logk = 4, m = 3551;
    typedef struct {int a; int b;} pair_t;
    logic clk = 0, rst_n = 0, start = 0;
    logic [k-1:0] x = '0, e = '0, z;
    logic done, busy;
    int errors = 0, checks = 0, done_cnt = 0, calls_seen = 0;
    int lat = 3, hold = 1, cnt = 0, hl = 0;
    int exp_z[$], exp_nc[$];
    pair_t exp_calls[$];
    mod_exp_ctrl_if #(.k(k)) mif();
    mod_exp_ctrl #(.k(k), .logk(logk)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .e(e),
        .z(z), .done(done), .busy(busy), .mm(mif)
    );
    always #5 clk = ~clk;
    // mod_mul model: lat cycles to answer, done held at least hold cycles and while start stays high
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mif.mul_done <= 1'b0;
            mif.mul_z    <= '0;
            cnt          <= 0;
            hl           <= 0;
        end else if (mif.mul_done) begin
            if (hl > 0) hl <= hl - 1;
            else if (!mif.mul_start) mif.mul_done <= 1'b0;
        end else if (mif.mul_start) begin
            if (cnt >= lat - 1) begin
                mif.mul_done <= 1'b1;
                mif.mul_z    <= k'((longint'(mif.mul_x) * longint'(mif.mul_y)) % m);
                hl           <= hold - 1;
                cnt          <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask
    // reference: plain left-to-right binary exponentiation, recording each multiplier call
    task automatic ref_model(input int xv, input int ev, output int zz, output int nc);
        int r, l;
        pair_t p;
        nc = 0;
        zz = 1;
        if (ev != 0) begin
            l = $clog2(ev + 1);
            r = xv;
            for (int i = l - 2; i >= 0; i--) begin
                p.a = r; p.b = r;
                exp_calls.push_back(p);
                r = (r * r) % m;
                nc++;
                if (ev[i]) begin
                    p.a = r; p.b = xv;
                    exp_calls.push_back(p);
                    r = (r * xv) % m;
                    nc++;
                end
            end
            zz = r;
        end
    endtask
    task automatic issue(input int xv, input int ev, input int ez, input int ec);
        int zz, nc;
        ref_model(xv, ev, zz, nc);
        exp_z.push_back(ez < 0 ? zz : ez);
        exp_nc.push_back(ec < 0 ? nc : ec);
        @(negedge clk);
        x = xv[k-1:0];
        e = ev[k-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_set", busy, 1);
    endtask
    task automatic wait_done(input int tgt);
        for (int i = 0; i < 5000 && done_cnt < tgt; i++) @(negedge clk);
        if (done_cnt < tgt) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d dones expected %0d", done_cnt, tgt);
        end
        @(negedge clk);
    endtask
    task automatic run(input int xv, input int ev, input int ez, input int ec);
        int tgt;
        tgt = done_cnt + 1;
        issue(xv, ev, ez, ec);
        wait_done(tgt);
    endtask
    // monitor: pops the scoreboard whenever the DUT presents a call or a result
    initial begin
        logic prev_done, prev_ms;
        logic [k-1:0] hx, hy;
        pair_t p;
        prev_done = 0; prev_ms = 0; hx = '0; hy = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_z.delete();
                exp_nc.delete();
                exp_calls.delete();
                calls_seen = 0;
            end else begin
                if (prev_done) begin
                    chk("done_one_cycle", done, 0);
                    chk("busy_after_done", busy, 0);
                end
                if (done) begin
                    chk("busy_in_done", busy, 1);
                    if (exp_z.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got z=%0d expected no done", z);
                    end else begin
                        chk("z", z, exp_z.pop_front());
                        chk("call_count", calls_seen, exp_nc.pop_front());
                    end
                    calls_seen = 0;
                    done_cnt++;
                end
                if (mif.mul_start && !prev_ms) begin
                    calls_seen++;
                    hx = mif.mul_x;
                    hy = mif.mul_y;
                    if (exp_calls.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_call: got x=%0d y=%0d expected no call", hx, hy);
                    end else begin
                        p = exp_calls.pop_front();
                        chk("call_x", mif.mul_x, p.a);
                        chk("call_y", mif.mul_y, p.b);
                    end
                end else if (mif.mul_start) begin
                    chk("mul_x_stable", mif.mul_x, hx);
                    chk("mul_y_stable", mif.mul_y, hy);
                end
            end
            prev_done = done;
            prev_ms = mif.mul_start;
        end
    end
    initial begin
        int tgt;
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_z", z, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_start", mif.mul_start, 0);
        chk("rst_mul_x", mif.mul_x, 0);
        chk("rst_mul_y", mif.mul_y, 0);
        rst_n = 1'b1;
        run(2, 10, 1024, 4);
        run(3550, 3, 3550, 2);
        run(2, 12, 545, 4);
        run(1234, 1, 1234, 0);
        run(0, 0, 1, 0);
        run(5, 4095, -1, 22);
        tgt = done_cnt + 1;
        issue(3, 9, -1, 4);
        repeat (6) @(negedge clk);
        x = 12'd7;
        e = 12'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tgt);
        repeat (10) @(negedge clk);
        hold = 5;
        run(2, 10, 1024, 4);
        hold = 1;
        issue(5, 4095, -1, 22);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = mif.mul_start;
        end
        chk("call_reached", seen, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_z", z, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mul_start", mif.mul_start, 0);
        chk("abort_mul_x", mif.mul_x, 0);
        chk("abort_mul_y", mif.mul_y, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run(2, 10, 1024, 4);
        for (int n = 0; n < 25; n++) begin
            lat = int'($urandom_range(4, 1));
            hold = int'($urandom_range(3, 1));
            run(int'($urandom_range(m - 1, 0)), int'($urandom_range(4095, 0)), -1, -1);
        end
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
